// File: rtl/mm_fetch_scheduler_if.sv
// Handshake bundle shared by the fetch scheduler, the input-RAM read
// controller and the fault-tolerant compute core.
interface mm_fetch_scheduler_if;
  logic       start;
  logic       row_done;
  logic       fetch_A;
  logic       fetch_B;
  logic       b_load;
  logic [5:0] b_row_idx;
  logic       a_valid;
  logic [5:0] a_row_idx;
  logic [1:0] pass_id;
  logic       busy;
  logic       finish;
  logic       err;

  // Scheduler side: consumes the job request and the core's row_done.
  modport master (
    input  start, row_done,
    output fetch_A, fetch_B, b_load, b_row_idx, a_valid, a_row_idx,
           pass_id, busy, finish, err
  );

  // RAM controller / core side.
  modport slave (
    output start, row_done,
    input  fetch_A, fetch_B, b_load, b_row_idx, a_valid, a_row_idx,
           pass_id, busy, finish, err
  );
endinterface

// File: rtl/mm_fetch_scheduler.sv
// Job sequencer for one redundant matrix job: per pass it requests the
// B burst, captures N_ROWS B rows, then walks N_ROWS A rows plus one
// flush fetch, gated by the core's row_done. A watchdog aborts a stalled
// job with a sticky err flag.
module mm_fetch_scheduler #(
  parameter int N_ROWS       = 32,
  parameter int NUM_PASSES   = 3,
  parameter int RD_LAT       = 3,
  parameter int B_ROW_PERIOD = 6,
  parameter int TIMEOUT      = 255
) (
  input logic                  clk,
  input logic                  rst,
  mm_fetch_scheduler_if.master bus
);

  localparam int              WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [5:0]      LAST_ROW  = 6'(N_ROWS - 1);
  localparam logic [1:0]      LAST_PASS = 2'(NUM_PASSES - 1);
  localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX    = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_ONE    = WD_W'(1);
  // Countdown reloads: the strobe is raised when the counter reaches 1 so
  // that it lands exactly RD_LAT / B_ROW_PERIOD cycles after its trigger.
  localparam logic [7:0]      LAT_LOAD   = 8'(RD_LAT - 1);
  localparam logic [7:0]      ROW_LOAD   = 8'(B_ROW_PERIOD - 1);
  localparam logic [7:0]      FLUSH_LOAD = 8'(RD_LAT);

  typedef enum logic [3:0] {
    IDLE,
    B_REQ,
    B_STREAM,
    A_REQ,
    A_LAT,
    A_WAIT,
    FLUSH,
    FLUSH_WAIT,
    PASS_END,
    DONE
  } state_t;

  state_t          state;
  logic [7:0]      lat_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            start_q;
  logic            start_qq;
  logic            start_edge;

  logic            fetch_a;
  logic            fetch_b;
  logic            b_load;
  logic [5:0]      b_row_idx;
  logic            a_valid;
  logic [5:0]      a_row_idx;
  logic [1:0]      pass_id;
  logic            busy;
  logic            finish;
  logic            err;

  // Register the start level and detect its rising edge one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q  <= 1'b0;
      start_qq <= 1'b0;
    end else begin
      // NOTE: registers are updated with non-blocking assignments so every
      // flop samples the values present before the clock edge.
      start_q  <= bus.start;
      start_qq <= start_q;
    end
  end

  assign start_edge = start_q & ~start_qq;

  // Job FSM with registered strobes, indices, status and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      wd_cnt    <= '0;
      fetch_a   <= 1'b0;
      fetch_b   <= 1'b0;
      b_load    <= 1'b0;
      b_row_idx <= '0;
      a_valid   <= 1'b0;
      a_row_idx <= '0;
      pass_id   <= '0;
      busy      <= 1'b0;
      finish    <= 1'b0;
      err       <= 1'b0;
    end else begin
      fetch_a <= 1'b0;
      fetch_b <= 1'b0;
      b_load  <= 1'b0;
      a_valid <= 1'b0;
      finish  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state     <= B_REQ;
            fetch_b   <= 1'b1;
            busy      <= 1'b1;
            err       <= 1'b0;
            pass_id   <= '0;
            a_row_idx <= '0;
            b_row_idx <= '0;
          end
        end

        B_REQ: begin
          state     <= B_STREAM;
          lat_cnt   <= LAT_LOAD;
          b_row_idx <= '0;
        end

        B_STREAM: begin
          if (lat_cnt != 8'd0) begin
            lat_cnt <= lat_cnt - 8'd1;
            if (lat_cnt == 8'd1) b_load <= 1'b1;
          end else if (b_row_idx == LAST_ROW) begin
            state     <= A_REQ;
            fetch_a   <= 1'b1;
            a_row_idx <= '0;
          end else begin
            b_row_idx <= b_row_idx + 6'd1;
            lat_cnt   <= ROW_LOAD;
          end
        end

        A_REQ: begin
          state   <= A_LAT;
          lat_cnt <= LAT_LOAD;
        end

        A_LAT: begin
          lat_cnt <= lat_cnt - 8'd1;
          if (lat_cnt == 8'd1) begin
            state   <= A_WAIT;
            a_valid <= 1'b1;
            wd_cnt  <= '0;
          end
        end

        A_WAIT: begin
          if (bus.row_done) begin
            fetch_a <= 1'b1;
            if (a_row_idx == LAST_ROW) begin
              state <= FLUSH;
            end else begin
              state     <= A_REQ;
              a_row_idx <= a_row_idx + 6'd1;
            end
          end else if (wd_cnt == WD_LIMIT) begin
            wd_cnt <= WD_MAX;
            err    <= 1'b1;
            finish <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + WD_ONE;
          end
        end

        FLUSH: begin
          state   <= FLUSH_WAIT;
          lat_cnt <= FLUSH_LOAD;
        end

        FLUSH_WAIT: begin
          lat_cnt <= lat_cnt - 8'd1;
          if (lat_cnt == 8'd1) state <= PASS_END;
        end

        PASS_END: begin
          if (pass_id != LAST_PASS) begin
            pass_id <= pass_id + 2'd1;
            fetch_b <= 1'b1;
            state   <= B_REQ;
          end else begin
            finish <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.fetch_A   = fetch_a;
  assign bus.fetch_B   = fetch_b;
  assign bus.b_load    = b_load;
  assign bus.b_row_idx = b_row_idx;
  assign bus.a_valid   = a_valid;
  assign bus.a_row_idx = a_row_idx;
  assign bus.pass_id   = pass_id;
  assign bus.busy      = busy;
  assign bus.finish    = finish;
  assign bus.err       = err;

endmodule

// File: tb/tb_mm_fetch_scheduler.sv
// Self-checking bench for mm_fetch_scheduler. A responder answers each
// a_valid with row_done after a per-row delay; a monitor logs every strobe
// with its cycle; a job-level model predicts the same event list from the
// start cycle and the delay table.
module tb_mm_fetch_scheduler;

  localparam int N_ROWS       = 32;
  localparam int NUM_PASSES   = 3;
  localparam int RD_LAT       = 3;
  localparam int B_ROW_PERIOD = 6;
  localparam int TIMEOUT      = 255;

  localparam int EV_FB  = 0;
  localparam int EV_BL  = 1;
  localparam int EV_FA  = 2;
  localparam int EV_AV  = 3;
  localparam int EV_FIN = 4;

  typedef struct packed {
    int cyc;
    int kind;
    int idx;   // row index; err for EV_FIN
    int pass;  // pass_id; busy for EV_FIN
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic row_done;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  ev_t  obs[$];
  ev_t  exp_q[$];
  int   obs_base;
  int   s0;
  int   delay_tab[NUM_PASSES][N_ROWS];
  bit   stray_en;
  bit   outstanding;
  int   rd_wait;
  logic fb_seen[3];
  logic busy_seen[3];
  logic err_seen[3];

  mm_fetch_scheduler_if ifc();
  assign ifc.start    = start;
  assign ifc.row_done = row_done;

  mm_fetch_scheduler #(
    .N_ROWS(N_ROWS), .NUM_PASSES(NUM_PASSES), .RD_LAT(RD_LAT),
    .B_ROW_PERIOD(B_ROW_PERIOD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int c, input int k, input int i, input int p);
    ev_t e;
    e.cyc = c; e.kind = k; e.idx = i; e.pass = p;
    return e;
  endfunction

  // Core responder and event monitor, both working on the falling edge.
  always @(negedge clk) begin
    int d;
    row_done = 1'b0;
    if (rst === 1'b1) begin
      outstanding = 1'b0;
    end else if (outstanding) begin
      if (rd_wait == 0) begin
        row_done    = 1'b1;
        outstanding = 1'b0;
      end else begin
        rd_wait--;
      end
    end else if (ifc.a_valid === 1'b1) begin
      d = delay_tab[ifc.pass_id][ifc.a_row_idx];
      if (d == 0) row_done = 1'b1;
      else if (d > 0) begin
        outstanding = 1'b1;
        rd_wait     = d - 1;
      end
    end else if (stray_en && $urandom_range(0, 7) == 0) begin
      row_done = 1'b1;  // lands outside A_WAIT, must be ignored
    end

    if (ifc.fetch_B === 1'b1) obs.push_back(mk(cyc, EV_FB, 0, int'(ifc.pass_id)));
    if (ifc.b_load  === 1'b1) obs.push_back(mk(cyc, EV_BL, int'(ifc.b_row_idx), int'(ifc.pass_id)));
    if (ifc.fetch_A === 1'b1) obs.push_back(mk(cyc, EV_FA, int'(ifc.a_row_idx), int'(ifc.pass_id)));
    if (ifc.a_valid === 1'b1) obs.push_back(mk(cyc, EV_AV, int'(ifc.a_row_idx), int'(ifc.pass_id)));
    if (ifc.finish  === 1'b1) obs.push_back(mk(cyc, EV_FIN, int'(ifc.err), int'(ifc.busy)));
  end

  // Job-level prediction: fetch_B at s+2, B rows every B_ROW_PERIOD after
  // RD_LAT, each A row RD_LAT after its fetch, the next fetch one cycle
  // after row_done, flush then RD_LAT idle cycles and one pass-end cycle.
  task automatic build_model(input int start_cyc);
    int t, fa, av, d;
    bit dead;
    exp_q.delete();
    t = start_cyc + 2;
    dead = 1'b0;
    for (int p = 0; p < NUM_PASSES && !dead; p++) begin
      exp_q.push_back(mk(t, EV_FB, 0, p));
      for (int k = 0; k < N_ROWS; k++)
        exp_q.push_back(mk(t + RD_LAT + k * B_ROW_PERIOD, EV_BL, k, p));
      fa = t + RD_LAT + (N_ROWS - 1) * B_ROW_PERIOD + 1;
      for (int r = 0; r < N_ROWS && !dead; r++) begin
        exp_q.push_back(mk(fa, EV_FA, r, p));
        av = fa + RD_LAT;
        exp_q.push_back(mk(av, EV_AV, r, p));
        d = delay_tab[p][r];
        if (d < 0 || d >= TIMEOUT) begin
          exp_q.push_back(mk(av + TIMEOUT, EV_FIN, 1, 0));
          dead = 1'b1;
        end else begin
          fa = av + d + 1;
        end
      end
      if (!dead) begin
        exp_q.push_back(mk(fa, EV_FA, N_ROWS - 1, p));
        t = fa + RD_LAT + 2;
      end
    end
    if (!dead) exp_q.push_back(mk(t, EV_FIN, 0, 0));
  endtask

  task automatic set_delays(input int lo, input int hi);
    for (int p = 0; p < NUM_PASSES; p++)
      for (int r = 0; r < N_ROWS; r++)
        delay_tab[p][r] = int'($urandom_range(hi, lo));
  endtask

  // Raise start for three cycles, sampling fetch_B/busy/err on each.
  task automatic launch_job;
    start = 1'b0;
    repeat (3) @(negedge clk);
    obs_base = obs.size();
    start = 1'b1;
    s0 = cyc;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      fb_seen[j]   = ifc.fetch_B;
      busy_seen[j] = ifc.busy;
      err_seen[j]  = ifc.err;
    end
    start = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ifc.finish === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    stray_en = 1'b0;
    set_delays(0, 0);
    repeat (5) @(negedge clk);
    checks++;
    if ({ifc.fetch_A, ifc.fetch_B, ifc.b_load, ifc.a_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset strobes: got %b want 0000", {ifc.fetch_A, ifc.fetch_B, ifc.b_load, ifc.a_valid});
    end
    checks++;
    if ({ifc.busy, ifc.finish, ifc.err} !== 3'b0) begin
      errors++;
      $display("FAIL reset status: got %b want 000", {ifc.busy, ifc.finish, ifc.err});
    end
    checks++;
    if ({ifc.a_row_idx, ifc.b_row_idx, ifc.pass_id} !== 14'b0) begin
      errors++;
      $display("FAIL reset indices: got a=%0d b=%0d pass=%0d want 0", ifc.a_row_idx, ifc.b_row_idx, ifc.pass_id);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_and_pass;
    bit ok;
    int n_fb, n_bl, n_fa, n_av;
    set_delays(0, 0);
    stray_en = 1'b0;
    launch_job();
    checks++;
    if ({fb_seen[0], fb_seen[1], fb_seen[2]} !== 3'b010) begin
      errors++;
      $display("FAIL start fetch_B timing: got %b want 010", {fb_seen[0], fb_seen[1], fb_seen[2]});
    end
    checks++;
    if ({busy_seen[0], busy_seen[1], busy_seen[2]} !== 3'b011) begin
      errors++;
      $display("FAIL start busy timing: got %b want 011", {busy_seen[0], busy_seen[1], busy_seen[2]});
    end
    wait_finish(20000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL start_pass finish: got none want pulse"); end
    build_model(s0);
    checks++;
    if (obs.size() - obs_base !== exp_q.size()) begin
      errors++;
      $display("FAIL start_pass event count: got %0d want %0d", obs.size() - obs_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && obs_base + i < obs.size(); i++) begin
      checks++;
      if (obs[obs_base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL start_pass event %0d: got cyc=%0d kind=%0d idx=%0d pass=%0d want cyc=%0d kind=%0d idx=%0d pass=%0d",
                 i, obs[obs_base + i].cyc, obs[obs_base + i].kind, obs[obs_base + i].idx, obs[obs_base + i].pass,
                 exp_q[i].cyc, exp_q[i].kind, exp_q[i].idx, exp_q[i].pass);
        break;
      end
    end
    n_fb = 0; n_bl = 0; n_fa = 0; n_av = 0;
    for (int i = obs_base; i < obs.size(); i++) begin
      if (obs[i].kind != EV_FIN && obs[i].pass == 0) begin
        if (obs[i].kind == EV_FB) n_fb++;
        if (obs[i].kind == EV_BL) n_bl++;
        if (obs[i].kind == EV_FA) n_fa++;
        if (obs[i].kind == EV_AV) n_av++;
      end
    end
    checks++;
    if (n_fb != 1 || n_bl != 32 || n_fa != 33 || n_av != 32) begin
      errors++;
      $display("FAIL pass0 counts: got fb=%0d bl=%0d fa=%0d av=%0d want 1 32 33 32", n_fb, n_bl, n_fa, n_av);
    end
  endtask

  task automatic test_full_job;
    bit ok;
    int n_fb, n_fa, n_fin;
    int pass_seq[$];
    set_delays(0, 8);
    stray_en = 1'b1;
    launch_job();
    wait_finish(20000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_job finish: got none want pulse"); end
    build_model(s0);
    checks++;
    if (obs.size() - obs_base !== exp_q.size()) begin
      errors++;
      $display("FAIL full_job event count: got %0d want %0d", obs.size() - obs_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && obs_base + i < obs.size(); i++) begin
      checks++;
      if (obs[obs_base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_job event %0d: got cyc=%0d kind=%0d idx=%0d pass=%0d want cyc=%0d kind=%0d idx=%0d pass=%0d",
                 i, obs[obs_base + i].cyc, obs[obs_base + i].kind, obs[obs_base + i].idx, obs[obs_base + i].pass,
                 exp_q[i].cyc, exp_q[i].kind, exp_q[i].idx, exp_q[i].pass);
        break;
      end
    end
    n_fb = 0; n_fa = 0; n_fin = 0;
    for (int i = obs_base; i < obs.size(); i++) begin
      if (obs[i].kind == EV_FB) begin n_fb++; pass_seq.push_back(obs[i].pass); end
      if (obs[i].kind == EV_FA) n_fa++;
      if (obs[i].kind == EV_FIN) n_fin++;
    end
    checks++;
    if (n_fa != 99 || n_fb != 3 || n_fin != 1) begin
      errors++;
      $display("FAIL full_job totals: got fa=%0d fb=%0d fin=%0d want 99 3 1", n_fa, n_fb, n_fin);
    end
    checks++;
    if (pass_seq.size() != 3 || pass_seq[0] != 0 || pass_seq[1] != 1 || pass_seq[2] != 2) begin
      errors++;
      $display("FAIL full_job pass sequence: got %0d passes want 0,1,2", pass_seq.size());
    end
    checks++;
    if (ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL full_job busy after: got %b want 0", ifc.busy);
    end
  endtask

  task automatic test_back_pressure;
    bit ok;
    set_delays(0, 5);
    delay_tab[1][17] = 40;
    stray_en = 1'b1;
    launch_job();
    repeat (600) @(negedge clk);
    pulse_start();  // edge while busy: ignored, not queued
    wait_finish(20000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL back_pressure finish: got none want pulse"); end
    build_model(s0);
    checks++;
    if (obs.size() - obs_base !== exp_q.size()) begin
      errors++;
      $display("FAIL back_pressure event count: got %0d want %0d", obs.size() - obs_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && obs_base + i < obs.size(); i++) begin
      checks++;
      if (obs[obs_base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL back_pressure event %0d: got cyc=%0d kind=%0d idx=%0d pass=%0d want cyc=%0d kind=%0d idx=%0d pass=%0d",
                 i, obs[obs_base + i].cyc, obs[obs_base + i].kind, obs[obs_base + i].idx, obs[obs_base + i].pass,
                 exp_q[i].cyc, exp_q[i].kind, exp_q[i].idx, exp_q[i].pass);
        break;
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL back_pressure no restart: got busy=%b want 0", ifc.busy);
    end
  endtask

  task automatic test_watchdog;
    bit ok;
    int av_cyc, fin_cyc;
    set_delays(0, 0);
    delay_tab[0][5] = -1;
    stray_en = 1'b0;
    launch_job();
    wait_finish(20000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL watchdog finish: got none want pulse"); end
    build_model(s0);
    checks++;
    if (obs.size() - obs_base !== exp_q.size()) begin
      errors++;
      $display("FAIL watchdog event count: got %0d want %0d", obs.size() - obs_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && obs_base + i < obs.size(); i++) begin
      checks++;
      if (obs[obs_base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL watchdog event %0d: got cyc=%0d kind=%0d idx=%0d pass=%0d want cyc=%0d kind=%0d idx=%0d pass=%0d",
                 i, obs[obs_base + i].cyc, obs[obs_base + i].kind, obs[obs_base + i].idx, obs[obs_base + i].pass,
                 exp_q[i].cyc, exp_q[i].kind, exp_q[i].idx, exp_q[i].pass);
        break;
      end
    end
    av_cyc = -1; fin_cyc = -1;
    for (int i = obs_base; i < obs.size(); i++) begin
      if (obs[i].kind == EV_AV && obs[i].idx == 5 && obs[i].pass == 0) av_cyc = obs[i].cyc;
      if (obs[i].kind == EV_FIN) fin_cyc = obs[i].cyc;
    end
    checks++;
    if (av_cyc < 0 || fin_cyc - av_cyc != TIMEOUT) begin
      errors++;
      $display("FAIL watchdog latency: got %0d want %0d", fin_cyc - av_cyc, TIMEOUT);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (ifc.err !== 1'b1) begin
      errors++;
      $display("FAIL watchdog err sticky: got %b want 1", ifc.err);
    end
    set_delays(0, 0);
    launch_job();
    checks++;
    if ({err_seen[0], err_seen[1], err_seen[2]} !== 3'b100) begin
      errors++;
      $display("FAIL watchdog err clear on start: got %b want 100", {err_seen[0], err_seen[1], err_seen[2]});
    end
    wait_finish(20000, ok);
    checks++;
    if (!ok || obs[obs.size() - 1].kind != EV_FIN || obs[obs.size() - 1].idx != 0) begin
      errors++;
      $display("FAIL watchdog clean job: got finish=%b err=%0d want finish with err 0", ok, obs[obs.size() - 1].idx);
    end
  endtask

  task automatic test_reset_mid_job;
    bit ok;
    int n_fb, n_fin;
    set_delays(0, 4);
    stray_en = 1'b1;
    launch_job();
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (ifc.pass_id === 2'd2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_reset reach pass 2: got pass=%0d want 2", ifc.pass_id); end
    repeat (40) @(negedge clk);
    pulse_start();
    repeat (10) @(negedge clk);
    n_fb = 0; n_fin = 0;
    for (int i = obs_base; i < obs.size(); i++) begin
      if (obs[i].kind == EV_FB) n_fb++;
      if (obs[i].kind == EV_FIN) n_fin++;
    end
    checks++;
    if (ifc.busy !== 1'b1 || ifc.pass_id !== 2'd2 || n_fb != 3 || n_fin != 0) begin
      errors++;
      $display("FAIL mid_reset start ignored: got busy=%b pass=%0d fb=%0d fin=%0d want 1 2 3 0",
               ifc.busy, ifc.pass_id, n_fb, n_fin);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ifc.fetch_A, ifc.fetch_B, ifc.b_load, ifc.a_valid, ifc.busy, ifc.finish, ifc.err} !== 7'b0 ||
        {ifc.a_row_idx, ifc.b_row_idx, ifc.pass_id} !== 14'b0) begin
      errors++;
      $display("FAIL mid_reset async clear: got busy=%b pass=%0d a=%0d b=%0d want all 0",
               ifc.busy, ifc.pass_id, ifc.a_row_idx, ifc.b_row_idx);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    obs_base = obs.size();
    repeat (20) @(negedge clk);
    checks++;
    if (obs.size() != obs_base || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset stays idle: got %0d events busy=%b want 0 events busy 0",
               obs.size() - obs_base, ifc.busy);
    end
  endtask

  initial begin
    test_reset();
    test_start_and_pass();
    test_full_job();
    test_back_pressure();
    test_watchdog();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got no completion want completion");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
